// File: rtl/tmr_vote_stage.sv
// tmr_vote_stage: triple-modular-redundancy voter with a one-deep registered
// output stage, lane-health tracking (NORMAL / SUSPECT / FAILED) and an
// optional saturating error counter enabled by macro TMR_VOTE_ERRCNT_EN.
module tmr_vote_stage #(
  parameter int W            = 8,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 8
) (
  input  logic             CP,
  input  logic             CD,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [W-1:0]     C,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [W-1:0]     Z,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             ERR,
  output logic             MULTI,
  output logic [1:0]       FAIL_LANE,
  output logic [CNT_W-1:0] ERR_CNT,
  input  logic             CLR_CNT
);

  localparam logic [1:0] LANE_NONE = 2'b00;
  localparam logic [1:0] LANE_A    = 2'b01;
  localparam logic [1:0] LANE_B    = 2'b10;
  localparam logic [1:0] LANE_C    = 2'b11;
  localparam logic [3:0] THRESH    = 4'(FAULT_THRESH);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAILED  = 2'd2
  } health_e;

  // Bitwise 2-of-3 majority.
  function automatic logic [W-1:0] maj3(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Registered state
  health_e        state_q;
  logic [1:0]     lane_q;
  logic [3:0]     run_q;
  logic [1:0]     fail_lane_q;
  logic [W-1:0]   z_q;
  logic           err_q;
  logic           multi_q;
  logic           out_valid_q;
  logic           armed_q;

  // Combinational vote of the incoming beat
  logic [W-1:0]   z_d;
  logic           err_d;
  logic           multi_d;
  logic           single_d;
  logic [1:0]     single_lane_d;
  logic           diff_a_s;
  logic           diff_b_s;
  logic           diff_c_s;
  logic [1:0]     n_diff_s;
  logic           accept_s;

  assign IN_READY  = ~out_valid_q | OUT_READY;
  // armed_q blocks acceptance on the first edge after reset release.
  assign accept_s  = IN_VALID & IN_READY & armed_q;

  assign Z         = z_q;
  assign ERR       = err_q;
  assign MULTI     = multi_q;
  assign OUT_VALID = out_valid_q;
  assign FAIL_LANE = fail_lane_q;

  // Vote the incoming replicas: majority while healthy, surviving lanes once a lane has failed.
  always_comb begin
    z_d           = maj3(A, B, C);
    diff_a_s      = 1'b0;
    diff_b_s      = 1'b0;
    diff_c_s      = 1'b0;
    n_diff_s      = 2'd0;
    err_d         = 1'b0;
    multi_d       = 1'b0;
    single_d      = 1'b0;
    single_lane_d = LANE_NONE;
    case (fail_lane_q)
      LANE_NONE: begin
        diff_a_s = (A != z_d);
        diff_b_s = (B != z_d);
        diff_c_s = (C != z_d);
        n_diff_s = {1'b0, diff_a_s} + {1'b0, diff_b_s} + {1'b0, diff_c_s};
        err_d    = (n_diff_s != 2'd0);
        multi_d  = (n_diff_s >= 2'd2);
        single_d = (n_diff_s == 2'd1);
        if (diff_a_s) begin
          single_lane_d = LANE_A;
        end else if (diff_b_s) begin
          single_lane_d = LANE_B;
        end else if (diff_c_s) begin
          single_lane_d = LANE_C;
        end else begin
          single_lane_d = LANE_NONE;
        end
      end
      LANE_A: begin
        z_d     = B;
        err_d   = (B != C);
        multi_d = (B != C);
      end
      LANE_B: begin
        z_d     = A;
        err_d   = (A != C);
        multi_d = (A != C);
      end
      LANE_C: begin
        z_d     = A;
        err_d   = (A != B);
        multi_d = (A != B);
      end
      default: begin
        z_d     = maj3(A, B, C);
        err_d   = 1'b0;
        multi_d = 1'b0;
      end
    endcase
  end

  // Lane-health FSM: tracks consecutive single-lane mismatches and latches a failed lane.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q     <= ST_NORMAL;
      lane_q      <= LANE_NONE;
      run_q       <= 4'd0;
      fail_lane_q <= LANE_NONE;
    end else if (accept_s) begin
      case (state_q)
        ST_NORMAL: begin
          if (single_d) begin
            state_q <= ST_SUSPECT;
            lane_q  <= single_lane_d;
            run_q   <= 4'd1;
          end else begin
            state_q <= ST_NORMAL;
          end
        end
        ST_SUSPECT: begin
          if (single_d && (single_lane_d == lane_q)) begin
            if ((run_q + 4'd1) == THRESH) begin
              state_q     <= ST_FAILED;
              fail_lane_q <= lane_q;
            end else begin
              run_q <= run_q + 4'd1;
            end
          end else if (single_d) begin
            lane_q <= single_lane_d;
            run_q  <= 4'd1;
          end else begin
            state_q <= ST_NORMAL;
            lane_q  <= LANE_NONE;
            run_q   <= 4'd0;
          end
        end
        ST_FAILED: begin
          state_q <= ST_FAILED;
        end
        default: begin
          state_q <= ST_NORMAL;
          lane_q  <= LANE_NONE;
          run_q   <= 4'd0;
        end
      endcase
    end else begin
      state_q <= state_q;
    end
  end

  // Output holding register: load on accept, drop valid on drain, otherwise hold.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      err_q       <= 1'b0;
      multi_q     <= 1'b0;
    end else if (accept_s) begin
      out_valid_q <= 1'b1;
      z_q         <= z_d;
      err_q       <= err_d;
      multi_q     <= multi_d;
    end else if (OUT_READY) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  // Acceptance enable: stays low for exactly the first edge after reset release.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

`ifdef TMR_VOTE_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Saturating count of accepted erroneous beats; clear wins over increment.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      err_cnt_q <= '0;
    end else if (CLR_CNT) begin
      err_cnt_q <= '0;
    end else if (accept_s && err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign ERR_CNT = err_cnt_q;
`else
  logic unused_clr_cnt_s;

  assign unused_clr_cnt_s = CLR_CNT;
  assign ERR_CNT          = '0;
`endif

endmodule

// File: tb/tb_tmr_vote_stage.sv
// Self-checking bench for tmr_vote_stage: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model.
module tb_tmr_vote_stage;

  localparam int W  = 8;
  localparam int FT = 4;
  localparam int CW = 8;
`ifdef TMR_VOTE_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          CP = 1'b0;
  logic          CD = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [W-1:0]  C = '0;
  logic          IN_VALID = 1'b0;
  logic          OUT_READY = 1'b0;
  logic          CLR_CNT = 1'b0;
  logic          IN_READY;
  logic [W-1:0]  Z;
  logic          OUT_VALID;
  logic          ERR;
  logic          MULTI;
  logic [1:0]    FAIL_LANE;
  logic [CW-1:0] ERR_CNT;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit           m_ov;
  logic [W-1:0] m_z;
  bit           m_err;
  bit           m_multi;
  int           m_fail;   // 0 none, 1 A, 2 B, 3 C
  int           m_susp;   // lane currently suspected, 0 none
  int           m_run;    // consecutive mismatches of m_susp
  int           m_cnt;
  bit           m_armed;

  tmr_vote_stage #(.W(W), .FAULT_THRESH(FT), .CNT_W(CW)) dut (
    .CP        (CP),
    .CD        (CD),
    .A         (A),
    .B         (B),
    .C         (C),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .Z         (Z),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .ERR       (ERR),
    .MULTI     (MULTI),
    .FAIL_LANE (FAIL_LANE),
    .ERR_CNT   (ERR_CNT),
    .CLR_CNT   (CLR_CNT)
  );

  always #5 CP = ~CP;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_z = '0; m_err = 1'b0; m_multi = 1'b0;
    m_fail = 0; m_susp = 0; m_run = 0; m_cnt = 0; m_armed = 1'b0;
  endtask

  task automatic model_step();
    logic [W-1:0] ln [3];
    logic [W-1:0] z;
    int ones, nd, bad, s0, s1;
    bit acc, e, mu;
    ln[0] = A; ln[1] = B; ln[2] = C;
    z = '0; e = 1'b0; mu = 1'b0;
    acc = m_armed && IN_VALID && (!m_ov || OUT_READY);
    if (acc) begin
      if (m_fail == 0) begin
        for (int i = 0; i < W; i++) begin
          ones = int'(ln[0][i]) + int'(ln[1][i]) + int'(ln[2][i]);
          z[i] = (ones >= 2);
        end
        nd = 0; bad = 0;
        for (int k = 0; k < 3; k++) begin
          if (ln[k] != z) begin nd++; bad = k + 1; end
        end
        e = (nd > 0); mu = (nd >= 2);
        if (nd == 1) begin
          if (bad == m_susp) m_run++;
          else begin m_susp = bad; m_run = 1; end
          if (m_run >= FT) m_fail = bad;
        end else begin
          m_susp = 0; m_run = 0;
        end
      end else begin
        s0 = (m_fail == 1) ? 1 : 0;
        s1 = (m_fail == 3) ? 1 : 2;
        z = ln[s0]; e = (ln[s0] != ln[s1]); mu = e;
      end
      m_z = z; m_err = e; m_multi = mu; m_ov = 1'b1;
    end else if (OUT_READY) begin
      m_ov = 1'b0;
    end
    if (CNT_EN) begin
      if (CLR_CNT) m_cnt = 0;
      else if (acc && e && (m_cnt < (1 << CW) - 1)) m_cnt++;
    end
    m_armed = 1'b1;
  endtask

  // Reference model follows the clock and the asynchronous reset.
  always @(posedge CP or negedge CD) begin
    if (!CD) model_reset();
    else model_step();
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CP) begin
    chk("out_valid", OUT_VALID, m_ov);
    chk("in_ready", IN_READY, (!m_ov || OUT_READY));
    chk("fail_lane", FAIL_LANE, m_fail);
    chk("err_cnt", ERR_CNT, m_cnt);
    if (m_ov) begin
      chk("z", Z, m_z);
      chk("err", ERR, m_err);
      chk("multi", MULTI, m_multi);
    end
  end

  task automatic tick();
    @(posedge CP);
    #2;
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    A = a; B = b; C = c; IN_VALID = 1'b1; OUT_READY = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    CD = 1'b0; IN_VALID = 1'b0; CLR_CNT = 1'b0;
    #1;
    chk("rst_out_valid", OUT_VALID, 1'b0);
    chk("rst_z", Z, 8'h00);
    chk("rst_err", ERR, 1'b0);
    chk("rst_multi", MULTI, 1'b0);
    chk("rst_fail_lane", FAIL_LANE, 2'b00);
    chk("rst_err_cnt", ERR_CNT, 8'h00);
    chk("rst_in_ready", IN_READY, 1'b1);
    tick();
    CD = 1'b1;
    tick();
  endtask

  function automatic logic [W-1:0] flip(input logic [W-1:0] x);
    logic [W-1:0] m;
    m = W'($urandom_range(1, 255));
    return x ^ m;
  endfunction

  initial begin
    logic [W-1:0] base, ra, rb, rc;
    int lane;

    // Reset state and no-accept on the first edge after release
    #1;
    chk("init_out_valid", OUT_VALID, 1'b0);
    chk("init_z", Z, 8'h00);
    chk("init_in_ready", IN_READY, 1'b1);
    chk("init_fail_lane", FAIL_LANE, 2'b00);
    tick(); tick();
    CD = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
    A = 8'h11; B = 8'h11; C = 8'h11;
    tick();
    chk("first_edge_no_accept", OUT_VALID, 1'b0);

    // Clean beat
    beat(8'h5A, 8'h5A, 8'h5A);
    chk("clean_valid", OUT_VALID, 1'b1);
    chk("clean_z", Z, 8'h5A);
    chk("clean_err", ERR, 1'b0);
    chk("clean_multi", MULTI, 1'b0);

    // Single C corruption, then run to FAILED(C)
    beat(8'h5A, 8'h5A, 8'hFF);
    chk("c1_z", Z, 8'h5A);
    chk("c1_err", ERR, 1'b1);
    chk("c1_multi", MULTI, 1'b0);
    chk("c1_cnt", ERR_CNT, CNT_EN ? 8'd1 : 8'd0);
    beat(8'h5A, 8'h5A, 8'hFF);
    beat(8'h5A, 8'h5A, 8'hFF);
    chk("c3_fail_lane", FAIL_LANE, 2'b00);
    beat(8'h5A, 8'h5A, 8'hFF);
    chk("c4_fail_lane", FAIL_LANE, 2'b11);
    beat(8'h01, 8'h02, 8'h03);
    chk("failed_z", Z, 8'h01);
    chk("failed_err", ERR, 1'b1);
    chk("failed_multi", MULTI, 1'b1);
    chk("failed_cnt", ERR_CNT, CNT_EN ? 8'd5 : 8'd0);
    beat(8'h01, 8'h01, 8'h77);
    chk("failed_clean_z", Z, 8'h01);
    chk("failed_clean_err", ERR, 1'b0);
    chk("failed_sticky", FAIL_LANE, 2'b11);

    // Backpressure: hold for three cycles, then drain and accept together
    do_reset();
    A = 8'h33; B = 8'h33; C = 8'h33; IN_VALID = 1'b1; OUT_READY = 1'b0;
    tick();
    A = 8'h44; B = 8'h44; C = 8'h44;
    #1;
    chk("bp_in_ready", IN_READY, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_z", Z, 8'h33);
      chk("bp_hold_valid", OUT_VALID, 1'b1);
      chk("bp_hold_ready", IN_READY, 1'b0);
    end
    OUT_READY = 1'b1;
    #1;
    chk("bp_release_ready", IN_READY, 1'b1);
    tick();
    chk("bp_new_z", Z, 8'h44);
    chk("bp_new_valid", OUT_VALID, 1'b1);
    IN_VALID = 1'b0;
    tick();
    chk("bp_drained", OUT_VALID, 1'b0);

    // Reset while holding a beat in SUSPECT(B,2)
    beat(8'h10, 8'hEF, 8'h10);
    beat(8'h10, 8'hEF, 8'h10);
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    chk("pre_rst_valid", OUT_VALID, 1'b1);
    chk("pre_rst_z", Z, 8'h10);
    do_reset();
    OUT_READY = 1'b1;
    tick();
    chk("post_rst_valid", OUT_VALID, 1'b0);
    beat(8'h10, 8'hEF, 8'h10);
    beat(8'h10, 8'hEF, 8'h10);
    beat(8'h10, 8'hEF, 8'h10);
    chk("post_rst_normal", FAIL_LANE, 2'b00);
    beat(8'h10, 8'hEF, 8'h10);
    chk("post_rst_fail_b", FAIL_LANE, 2'b10);

    // Counter saturation and clear priority
    do_reset();
    for (int i = 0; i < 260; i++) beat(8'h01, 8'h02, 8'h04);
    chk("sat_multi", MULTI, 1'b1);
    chk("sat_cnt", ERR_CNT, CNT_EN ? 8'hFF : 8'h00);
    CLR_CNT = 1'b1;
    beat(8'h01, 8'h02, 8'h04);
    chk("clr_cnt", ERR_CNT, 8'h00);
    CLR_CNT = 1'b0;
    beat(8'h01, 8'h02, 8'h04);
    chk("after_clr_cnt", ERR_CNT, CNT_EN ? 8'd1 : 8'd0);

    // Randomized traffic; model comparison runs every cycle
    do_reset();
    for (int cyc = 0; cyc < 2048; cyc++) begin
      if ((cyc % 256 == 0) && (cyc > 0)) do_reset();
      base = W'($urandom);
      ra = base; rb = base; rc = base;
      if ((cyc / 64) % 2 == 1) begin
        lane = (cyc / 128) % 3;
        if (lane == 0) ra = flip(base);
        else if (lane == 1) rb = flip(base);
        else rc = flip(base);
      end else begin
        case ($urandom_range(0, 5))
          2: begin
            lane = $urandom_range(0, 2);
            if (lane == 0) ra = flip(base);
            else if (lane == 1) rb = flip(base);
            else rc = flip(base);
          end
          3: begin ra = flip(base); rb = flip(base); end
          4: begin ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); end
          default: begin ra = base; end
        endcase
      end
      A = ra; B = rb; C = rc;
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 3) != 0);
      CLR_CNT   = ($urandom_range(0, 31) == 0);
      tick();
    end

    IN_VALID = 1'b0; CLR_CNT = 1'b0; OUT_READY = 1'b1;
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
